ecc_read_checker: RTL and testbench
===================================

Name: ecc_read_checker

Overview:
- Read-side ECC stage for 128-bit SRAM words stored with an 8-bit SEC code.
- Recomputes the code over the read data and forms the syndrome. Corrects any single-bit data error, flags syndromes that cannot be decoded, and forwards the corrected word downstream.
- Two-stage pipeline with valid/ready backpressure. Also keeps error statistics and a first-error log for debug.
- Counterpart of the write-side ecc_encoder; the code definition below matches it bit for bit.

Parameters:
- DATA_W, 128, data width (fixed by the code definition; other values are unsupported).
- CODE_W, 8, SEC code width.
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  raw read word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  128  data read from SRAM.
- in_code  in  8  stored sec_code read from SRAM.
- out_vld  out  1  corrected word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  128  corrected data.
- out_corr  out  1  a single-bit error was corrected (data or code bit).
- out_uncorr  out  1  syndrome is invalid; out_data equals raw in_data.
- corr_cnt  out  CNT_W  count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.
- log_vld  out  1  first-error log is holding an entry.
- log_syn  out  8  syndrome of the first error since the last clear.
- cnt_clr  in  1  synchronous clear of both counters and the log.

Behaviour:
- Code definition:
  - Hamming positions run 1..136. Power-of-two positions (1,2,4,…,128) hold code bits.
  - Data bit i occupies the i-th non-power-of-two position, in ascending order: data[0]→3, data[1]→5, data[2]→6, data[3]→7, data[4]→9, …, data[127]→136.
  - code[j] = XOR of all data bits whose position has bit j set.
- Syndrome: syn = recomputed_code XOR in_code.
  - syn==0: clean word.
  - syn is a power of two: code-bit error. out_corr=1, data passes unchanged.
  - syn maps to a data position (3..136, non-power-of-two): flip that data bit, out_corr=1.
  - syn > 136: out_uncorr=1, data passes unchanged.
- Pipeline:
  - S1 registers in_data, in_code and syn.
  - S2 registers the corrected data and the flags.
  - Latency is 2 cycles from in_vld&in_ready to out_vld when out_ready is held high. Full throughput is 1 word per cycle.
- Handshake:
  - A transfer occurs on vld&ready at either port.
  - in_ready = !S1_full || S1 advances this cycle. S1 advances when !S2_full || out_ready. in_ready may depend combinationally on out_ready.
  - While out_vld=1 and out_ready=0, out_data/out_corr/out_uncorr stay stable and no word is dropped or duplicated.
- Counters:
  - Increment only on the output transfer (out_vld&out_ready), not on entry to the pipeline.
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment: the counter becomes 0 and that event is lost.
- Log:
  - On the first output transfer with out_corr|out_uncorr while log_vld=0, capture that word's syn and set log_vld=1.
  - Later errors leave the log unchanged.
  - cnt_clr clears log_vld and log_syn.
  - An error transfer in the same cycle as cnt_clr is not logged.
- Reset (asynchronous, mid-operation included): all valids drop to 0 and in-flight words are discarded.
  - out_vld=0, in_ready=1 after the first post-reset edge (S1 empty), out_data=0, out_corr=0, out_uncorr=0, corr_cnt=0, uncorr_cnt=0, log_vld=0, log_syn=0.
- Flags and data are meaningful only while out_vld=1.

Test Plan:
- Clean word: in_data=128'hBEC327A2, in_code=encoder(128'hBEC327A2), out_ready=1 → 2 cycles later out_data=128'hBEC327A2, out_corr=0, out_uncorr=0, counters stay 0.
- Single data-bit error: code of 128'hBEC327A2 with in_data=128'hBEC327A3 (data[0] flipped) → out_data=128'hBEC327A2, out_corr=1, corr_cnt=1, log_vld=1, log_syn=8'h03.
- Code-bit error: clean data, in_code with bit 7 flipped → out_data unchanged, out_corr=1, log_syn=8'h80. Also sweep all 128 data bits and all 8 code bits singly; every case must be corrected.
- Invalid syndrome: choose flips giving syn=8'hFF → out_uncorr=1, out_data=raw data, uncorr_cnt increments.
- Backpressure: stream 8 words with random out_ready → outputs appear in order with no loss or duplication. in_ready=0 when both stages are full and out_ready=0. Output holds stable while stalled.
- Saturation/clear/reset: force corr_cnt to 16'hFFFF and send another error → stays 16'hFFFF. Assert cnt_clr in the same cycle as an error transfer → counter=0, log_vld=0. Assert rst_n=0 with 2 words in flight → out_vld drops immediately and no stale word appears after release.

Source files
------------

// File: rtl/ecc_read_checker.sv
// ecc_read_checker: read-side SEC stage for 128-bit SRAM words with an 8-bit
// Hamming code. S1 captures the raw word and its syndrome; S2 holds the
// corrected word and its error flags. Saturating error counters and a
// first-error syndrome log are updated when a word leaves the pipeline.
module ecc_read_checker #(
  parameter int DATA_W = 128,
  parameter int CODE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_vld,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              log_vld,
  output logic [CODE_W-1:0] log_syn,
  input  logic              cnt_clr
);

  // Highest Hamming position in use; any larger syndrome cannot be decoded.
  localparam logic [CODE_W-1:0] MAX_POS = CODE_W'(136);

  // Hamming position of data bit idx: the idx-th non-power-of-two in 1..136.
  function automatic logic [CODE_W-1:0] data_pos(input int idx);
    int cnt;
    logic [CODE_W-1:0] p;
    cnt = 0;
    p   = '0;
    for (int q = 1; q <= 136; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == idx) p = q[CODE_W-1:0];
        cnt++;
      end
    end
    return p;
  endfunction

  // Set of data bits that participate in code bit j.
  function automatic logic [DATA_W-1:0] code_mask(input int j);
    logic [DATA_W-1:0] m;
    logic [CODE_W-1:0] p;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      p    = data_pos(i);
      m[i] = p[j];
    end
    return m;
  endfunction

  logic [CODE_W-1:0] calc_code_w;
  logic [CODE_W-1:0] syn_w;
  logic [DATA_W-1:0] flip_w;
  logic [DATA_W-1:0] corr_data_w;
  logic              corr_w;
  logic              uncorr_w;

  logic              s1_full_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [CODE_W-1:0] s1_syn_q;

  logic              s2_full_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_corr_q;
  logic              s2_uncorr_q;
  logic [CODE_W-1:0] s2_syn_q;

  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;
  logic              log_vld_q, log_vld_d;
  logic [CODE_W-1:0] log_syn_q, log_syn_d;

  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // Recompute each code bit as the parity of its participating data bits.
  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_code
    localparam logic [DATA_W-1:0] MASK = code_mask(gi);
    assign calc_code_w[gi] = ^(in_data & MASK);
  end

  assign syn_w = calc_code_w ^ in_code;

  // Each data bit flips when the registered syndrome points at its position.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_flip
    localparam logic [CODE_W-1:0] POS = data_pos(gi);
    assign flip_w[gi] = (s1_syn_q == POS);
  end

  // Power-of-two syndromes (code-bit errors) match no data position, so the
  // data passes through; syndromes above 136 match nothing either.
  assign corr_data_w = s1_data_q ^ flip_w;
  assign uncorr_w    = (s1_syn_q > MAX_POS);
  assign corr_w      = (s1_syn_q != '0) && !uncorr_w;

  assign s1_adv   = !s2_full_q || out_ready;
  assign in_ready = !s1_full_q || s1_adv;
  assign in_fire  = in_vld && in_ready;
  assign out_fire = s2_full_q && out_ready;

  // S1: capture raw data and syndrome; the stored code is not needed later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_q <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
    end else if (in_fire) begin
      s1_full_q <= 1'b1;
      s1_data_q <= in_data;
      s1_syn_q  <= syn_w;
    end else if (s1_adv) begin
      s1_full_q <= 1'b0;
    end
  end

  // S2: hold corrected word and flags; frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_full_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_corr_q   <= 1'b0;
      s2_uncorr_q <= 1'b0;
      s2_syn_q    <= '0;
    end else if (s1_adv) begin
      s2_full_q <= s1_full_q;
      if (s1_full_q) begin
        s2_data_q   <= corr_data_w;
        s2_corr_q   <= corr_w;
        s2_uncorr_q <= uncorr_w;
        s2_syn_q    <= s1_syn_q;
      end
    end
  end

  // Statistics update on output transfers; clear wins over a same-cycle event.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    log_vld_d    = log_vld_q;
    log_syn_d    = log_syn_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      log_vld_d    = 1'b0;
      log_syn_d    = '0;
    end else if (out_fire) begin
      if (s2_corr_q && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (s2_uncorr_q && (uncorr_cnt_q != '1))
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      if ((s2_corr_q || s2_uncorr_q) && !log_vld_q) begin
        log_vld_d = 1'b1;
        log_syn_d = s2_syn_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      log_vld_q    <= 1'b0;
      log_syn_q    <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      log_vld_q    <= log_vld_d;
      log_syn_q    <= log_syn_d;
    end
  end

  assign out_vld    = s2_full_q;
  assign out_data   = s2_data_q;
  assign out_corr   = s2_corr_q;
  assign out_uncorr = s2_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
  assign log_vld    = log_vld_q;
  assign log_syn    = log_syn_q;

endmodule

// File: tb/tb_ecc_read_checker.sv
// tb_ecc_read_checker: directed tests for the read-side SEC checker.
module tb_ecc_read_checker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [7:0]   in_code = '0;
  logic         out_vld;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_corr;
  logic         out_uncorr;
  logic [15:0]  corr_cnt;
  logic [15:0]  uncorr_cnt;
  logic         log_vld;
  logic [7:0]   log_syn;
  logic         cnt_clr = 1'b0;

  int vecs = 0;
  int errs = 0;

  localparam logic [127:0] CLEAN = 128'hBEC327A2;
  localparam logic [127:0] PAT   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  ecc_read_checker #(.DATA_W(128), .CODE_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_ready(in_ready), .in_data(in_data), .in_code(in_code),
    .out_vld(out_vld), .out_ready(out_ready), .out_data(out_data),
    .out_corr(out_corr), .out_uncorr(out_uncorr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .log_vld(log_vld), .log_syn(log_syn), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // Reference encoder: the code equals the XOR of the Hamming positions of
  // all set data bits (data bits fill non-power-of-two positions in order).
  function automatic logic [7:0] enc(input logic [127:0] d);
    logic [7:0] c;
    int idx;
    c = 8'h00;
    idx = 0;
    for (int p = 1; p <= 136; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[idx]) c = c ^ p[7:0];
        idx++;
      end
    end
    return c;
  endfunction

  // Send one word into an empty pipeline with out_ready high, collect it.
  // lat counts falling edges after acceptance until out_vld (-1 on timeout).
  // clr drives cnt_clr during the output transfer cycle.
  task automatic xfer(input logic [127:0] d, input logic [7:0] c, input bit clr,
                      output logic [127:0] od, output logic oc, output logic ou,
                      output int lat);
    @(negedge clk);
    in_vld = 1'b1; in_data = d; in_code = c; out_ready = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = -1; od = '0; oc = 1'b0; ou = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_vld) begin
        od = out_data; oc = out_corr; ou = out_uncorr; lat = k;
        break;
      end
    end
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    $display("xfer data=%h code=%h -> out=%h corr=%0d uncorr=%0d lat=%0d",
             d, c, od, oc, ou, lat);
  endtask

  task automatic pulse_clear();
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (out_vld !== 1'b0) begin errs++; $display("FAIL rst_out_vld got %b want 0", out_vld); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    vecs++; if (out_vld !== 1'b0 || out_data !== '0 || out_corr !== 1'b0 || out_uncorr !== 1'b0)
      begin errs++; $display("FAIL rst_outputs got vld=%b data=%h corr=%b unc=%b want all 0", out_vld, out_data, out_corr, out_uncorr); end
    vecs++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0 || log_vld !== 1'b0 || log_syn !== 8'h0)
      begin errs++; $display("FAIL rst_stats got c=%h u=%h lv=%b ls=%h want 0", corr_cnt, uncorr_cnt, log_vld, log_syn); end
  endtask

  task automatic test_clean();
    logic [127:0] od; logic oc, ou; int lat;
    xfer(CLEAN, enc(CLEAN), 1'b0, od, oc, ou, lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL clean_latency got %0d want 2", lat); end
    vecs++; if (od !== CLEAN) begin errs++; $display("FAIL clean_data got %h want %h", od, CLEAN); end
    vecs++; if (oc !== 1'b0 || ou !== 1'b0) begin errs++; $display("FAIL clean_flags got corr=%b unc=%b want 0 0", oc, ou); end
    vecs++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0 || log_vld !== 1'b0)
      begin errs++; $display("FAIL clean_stats got c=%h u=%h lv=%b want 0 0 0", corr_cnt, uncorr_cnt, log_vld); end
  endtask

  task automatic test_data_error();
    logic [127:0] od; logic oc, ou; int lat;
    xfer(128'hBEC327A3, enc(CLEAN), 1'b0, od, oc, ou, lat);
    vecs++; if (od !== CLEAN) begin errs++; $display("FAIL derr_data got %h want %h", od, CLEAN); end
    vecs++; if (oc !== 1'b1 || ou !== 1'b0) begin errs++; $display("FAIL derr_flags got corr=%b unc=%b want 1 0", oc, ou); end
    vecs++; if (corr_cnt !== 16'd1) begin errs++; $display("FAIL derr_corr_cnt got %h want 0001", corr_cnt); end
    vecs++; if (log_vld !== 1'b1 || log_syn !== 8'h03) begin errs++; $display("FAIL derr_log got lv=%b syn=%h want 1 03", log_vld, log_syn); end
  endtask

  task automatic test_code_error();
    logic [127:0] od; logic oc, ou; int lat;
    pulse_clear();
    vecs++; if (corr_cnt !== 16'h0 || log_vld !== 1'b0) begin errs++; $display("FAIL idle_clear got c=%h lv=%b want 0 0", corr_cnt, log_vld); end
    xfer(CLEAN, enc(CLEAN) ^ 8'h80, 1'b0, od, oc, ou, lat);
    vecs++; if (od !== CLEAN || oc !== 1'b1 || ou !== 1'b0)
      begin errs++; $display("FAIL cerr_out got %h corr=%b unc=%b want %h 1 0", od, oc, ou, CLEAN); end
    vecs++; if (log_syn !== 8'h80 || corr_cnt !== 16'd1) begin errs++; $display("FAIL cerr_log got syn=%h c=%h want 80 0001", log_syn, corr_cnt); end
  endtask

  task automatic test_sweep();
    logic [127:0] od; logic oc, ou; int lat;
    for (int i = 0; i < 128; i++) begin
      xfer(PAT ^ (128'd1 << i), enc(PAT), 1'b0, od, oc, ou, lat);
      vecs++; if (od !== PAT || oc !== 1'b1 || ou !== 1'b0)
        begin errs++; $display("FAIL sweep_data_bit%0d got %h corr=%b unc=%b want %h 1 0", i, od, oc, ou, PAT); end
    end
    for (int j = 0; j < 8; j++) begin
      xfer(PAT, enc(PAT) ^ (8'd1 << j), 1'b0, od, oc, ou, lat);
      vecs++; if (od !== PAT || oc !== 1'b1 || ou !== 1'b0)
        begin errs++; $display("FAIL sweep_code_bit%0d got %h corr=%b unc=%b want %h 1 0", j, od, oc, ou, PAT); end
    end
    vecs++; if (corr_cnt !== 16'd137) begin errs++; $display("FAIL sweep_corr_cnt got %0d want 137", corr_cnt); end
    vecs++; if (log_syn !== 8'h80) begin errs++; $display("FAIL sweep_log_kept got %h want 80", log_syn); end
  endtask

  task automatic test_uncorrectable();
    logic [127:0] od; logic oc, ou; int lat;
    // data[0] flip contributes syndrome 03; code XOR FC brings it to FF.
    xfer(CLEAN ^ 128'd1, enc(CLEAN) ^ 8'hFC, 1'b0, od, oc, ou, lat);
    vecs++; if (od !== (CLEAN ^ 128'd1) || ou !== 1'b1 || oc !== 1'b0)
      begin errs++; $display("FAIL unc_ff got %h corr=%b unc=%b want %h 0 1", od, oc, ou, CLEAN ^ 128'd1); end
    vecs++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd137)
      begin errs++; $display("FAIL unc_cnts got u=%0d c=%0d want 1 137", uncorr_cnt, corr_cnt); end
    // Syndrome 137 is the first undecodable value.
    xfer(CLEAN, enc(CLEAN) ^ 8'h89, 1'b0, od, oc, ou, lat);
    vecs++; if (od !== CLEAN || ou !== 1'b1 || oc !== 1'b0)
      begin errs++; $display("FAIL unc_137 got %h corr=%b unc=%b want %h 0 1", od, oc, ou, CLEAN); end
    vecs++; if (uncorr_cnt !== 16'd2) begin errs++; $display("FAIL unc_cnt2 got %0d want 2", uncorr_cnt); end
  endtask

  task automatic test_backpressure();
    logic [127:0] clean_w [8];
    logic [127:0] raw_w [8];
    int wr, rd, occ, cyc;
    bit prev_stall;
    logic [127:0] prev_data;
    logic prev_corr;
    for (int i = 0; i < 8; i++) begin
      clean_w[i] = PAT ^ {96'h0, 32'hA5A5_0000 + 32'(i)};
      raw_w[i]   = (i % 2 == 0) ? (clean_w[i] ^ (128'd1 << (i * 17))) : clean_w[i];
    end
    wr = 0; rd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_corr = 1'b0;
    while (rd < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        vecs++; if (out_vld !== 1'b1 || out_data !== prev_data || out_corr !== prev_corr)
          begin errs++; $display("FAIL bp_stall_hold got vld=%b %h want 1 %h", out_vld, out_data, prev_data); end
      end
      out_ready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
      if (cyc > 150) out_ready = 1'b1;
      in_vld = (wr < 8);
      if (wr < 8) begin in_data = raw_w[wr]; in_code = enc(clean_w[wr]); end
      #1;
      occ = wr - rd;
      vecs++; if (in_ready !== ((occ == 2 && !out_ready) ? 1'b0 : 1'b1))
        begin errs++; $display("FAIL bp_in_ready occ=%0d oready=%b got %b", occ, out_ready, in_ready); end
      if (out_vld && out_ready) begin
        vecs++; if (out_data !== clean_w[rd] || out_corr !== (rd % 2 == 0))
          begin errs++; $display("FAIL bp_word%0d got %h corr=%b want %h", rd, out_data, out_corr, clean_w[rd]); end
        $display("bp word %0d out=%h corr=%0d", rd, out_data, out_corr);
        rd++;
      end
      prev_stall = out_vld && !out_ready;
      prev_data = out_data;
      prev_corr = out_corr;
      if (in_vld && in_ready) wr++;
    end
    @(negedge clk);
    in_vld = 1'b0; out_ready = 1'b1;
    vecs++; if (rd !== 8) begin errs++; $display("FAIL bp_count got %0d want 8", rd); end
    repeat (3) @(negedge clk);
    vecs++; if (out_vld !== 1'b0) begin errs++; $display("FAIL bp_no_dup got vld=%b want 0", out_vld); end
    vecs++; if (corr_cnt !== 16'd141) begin errs++; $display("FAIL bp_corr_cnt got %0d want 141", corr_cnt); end
  endtask

  task automatic test_clear_same_cycle();
    logic [127:0] od; logic oc, ou; int lat;
    xfer(CLEAN ^ 128'd2, enc(CLEAN), 1'b1, od, oc, ou, lat);
    vecs++; if (od !== CLEAN || oc !== 1'b1) begin errs++; $display("FAIL clr_word got %h corr=%b want %h 1", od, oc, CLEAN); end
    vecs++; if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin errs++; $display("FAIL clr_cnts got c=%h u=%h want 0 0", corr_cnt, uncorr_cnt); end
    vecs++; if (log_vld !== 1'b0 || log_syn !== 8'h0) begin errs++; $display("FAIL clr_log got lv=%b syn=%h want 0 00", log_vld, log_syn); end
    xfer(CLEAN ^ (128'd1 << 127), enc(CLEAN), 1'b0, od, oc, ou, lat);
    vecs++; if (od !== CLEAN || log_vld !== 1'b1 || log_syn !== 8'h88 || corr_cnt !== 16'd1)
      begin errs++; $display("FAIL post_clr_log got %h lv=%b syn=%h c=%0d want %h 1 88 1", od, log_vld, log_syn, corr_cnt, CLEAN); end
  endtask

  task automatic test_saturation();
    logic [127:0] od; logic oc, ou; int lat;
    pulse_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(negedge clk);
      in_vld = 1'b1; in_data = CLEAN ^ 128'd1; in_code = enc(CLEAN);
    end
    @(negedge clk);
    in_vld = 1'b0;
    repeat (4) @(negedge clk);
    vecs++; if (corr_cnt !== 16'hFFFE) begin errs++; $display("FAIL sat_pre got %h want FFFE", corr_cnt); end
    xfer(CLEAN ^ 128'd1, enc(CLEAN), 1'b0, od, oc, ou, lat);
    vecs++; if (corr_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got %h want FFFF", corr_cnt); end
    xfer(CLEAN ^ 128'd4, enc(CLEAN), 1'b0, od, oc, ou, lat);
    vecs++; if (corr_cnt !== 16'hFFFF || uncorr_cnt !== 16'h0)
      begin errs++; $display("FAIL sat_hold got c=%h u=%h want FFFF 0000", corr_cnt, uncorr_cnt); end
  endtask

  task automatic test_midop_reset();
    bit seen;
    @(negedge clk);
    out_ready = 1'b0; in_vld = 1'b1; in_data = PAT; in_code = enc(PAT);
    @(negedge clk);
    in_data = CLEAN; in_code = enc(CLEAN);
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    vecs++; if (out_vld !== 1'b1 || in_ready !== 1'b0)
      begin errs++; $display("FAIL mid_full got vld=%b ready=%b want 1 0", out_vld, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (out_vld !== 1'b0) begin errs++; $display("FAIL mid_rst_drop got vld=%b want 0", out_vld); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_vld) seen = 1'b1;
    end
    vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL mid_stale got out_vld seen=%b want 0", seen); end
    vecs++; if (out_data !== '0 || corr_cnt !== 16'h0 || log_vld !== 1'b0 || in_ready !== 1'b1)
      begin errs++; $display("FAIL mid_post got data=%h c=%h lv=%b rdy=%b want 0 0 0 1", out_data, corr_cnt, log_vld, in_ready); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_data_error();
    test_code_error();
    test_sweep();
    test_uncorrectable();
    test_backpressure();
    test_clear_same_cycle();
    test_saturation();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
